// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the round-robin mux arbiter
//
// Purpose : arbiter FSM state enum, requester count, select width and a
//           one-hot helper used by mux_share_arbiter and rr_pick.
// Ports   : none (package).
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick of the next requester
//
// Purpose : scans req starting at last_owner+1 and wrapping 7->0, so
//           last_owner itself is checked last (lowest priority).
// Ports   : req[7:0]        in  - request vector
//           last_owner[2:0] in  - most recently granted requester
//           found           out - at least one request seen
//           idx[2:0]        out - winning requester (0 when none)
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_owner,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // k == NUM_REQ wraps back onto last_owner, giving it lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_owner + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_share_arbiter.sv
// rtl/mux_share_arbiter.sv - 8-way round-robin arbiter driving a shared data mux
//
// Purpose : grants one of eight requesters ownership of a shared datapath and
//           forwards the owner's data slice. Ownership lasts until the owner
//           drops its request; with ARB_HOLD_TIMEOUT_EN defined it is also
//           released after HOLD_MAX consecutive grant cycles.
// Macro   : ARB_HOLD_TIMEOUT_EN - enables the hold timeout.
// Ports   : clk                  in  - clock, rising edge
//           reset                in  - asynchronous, active-high
//           req[7:0]             in  - request per requester
//           data_in[8*WIDTH-1:0] in  - requester i at [i*WIDTH +: WIDTH]
//           gnt[7:0]             out - one-hot owner (registered)
//           gnt_valid            out - gnt non-zero (registered)
//           sel[2:0]             out - binary owner index (registered)
//           data_out[WIDTH-1:0]  out - owner's data, 0 when no owner
module mux_share_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     gnt_valid,
  output logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         data_out
);

  // Four bits are only needed when the timeout may have to count to 8.
  localparam int CNT_W = (HOLD_MAX > 7) ? 4 : 3;

  arb_state_t       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [SEL_W-1:0] last_owner;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             hold_expired;
  logic             rearb;

  // In BUSY last_owner equals the current owner, so one picker serves both
  // the idle grant and the handoff/timeout case, and a timed-out owner is
  // automatically the last one considered.
  rr_pick u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .found      (pick_found),
    .idx        (pick_idx)
  );

`ifdef ARB_HOLD_TIMEOUT_EN
  assign hold_expired = (hold_cnt == CNT_W'(HOLD_MAX));
`else
  assign hold_expired = 1'b0;
`endif

  assign rearb = (state == IDLE) || !req[sel] || hold_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      sel        <= '0;
      gnt_valid  <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= SEL_W'(NUM_REQ - 1);
    end else if (rearb) begin
      if (pick_found) begin
        state      <= BUSY;
        gnt        <= onehot(pick_idx);
        sel        <= pick_idx;
        gnt_valid  <= 1'b1;
        hold_cnt   <= CNT_W'(1);
        last_owner <= pick_idx;
      end else begin
        state     <= IDLE;
        gnt       <= '0;
        sel       <= '0;
        gnt_valid <= 1'b0;
        hold_cnt  <= '0;
      end
    end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
      // Never passes HOLD_MAX: the expiry above re-arbitrates first.
      hold_cnt <= hold_cnt + 1'b1;
`else
      if (hold_cnt != CNT_W'(7)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
`endif
    end
  end

  // One 8:1 select per data bit, forced to zero without an owner.
  logic [NUM_REQ-1:0] column;

  always_comb begin
    data_out = '0;
    column   = '0;
    for (int b = 0; b < WIDTH; b++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        column[i] = data_in[i*WIDTH + b];
      end
      data_out[b] = gnt_valid & column[sel];
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb/tb_mux_share_arbiter.sv - self-checking bench for mux_share_arbiter
module tb_mux_share_arbiter;

  localparam int W  = 8;
  localparam int HM = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [7:0]     req;
  logic [8*W-1:0] data_in;
  logic [7:0]     gnt;
  logic           gnt_valid;
  logic [2:0]     sel;
  logic [W-1:0]   data_out;

  int tests = 0;
  int fails = 0;

  // Reference model: owner index (-1 = none), last owner, hold count.
  int m_owner;
  int m_last;
  int m_hold;

  mux_share_arbiter #(.WIDTH(W), .HOLD_MAX(HM)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .sel       (sel),
    .data_out  (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 7;
    m_hold  = 0;
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_edge();
    int pick;
    if (m_owner < 0 || !req[m_owner] || (TO_EN && m_hold == HM)) begin
      pick = -1;
      for (int k = 1; k <= 8; k++) begin
        if (pick < 0 && req[(m_last + k) % 8]) pick = (m_last + k) % 8;
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_last  = pick;
        m_hold  = 1;
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else if (TO_EN || m_hold < 7) begin
      m_hold++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0]   eg;
    logic [2:0]   es;
    logic         ev;
    logic [W-1:0] ed;
    if (m_owner >= 0) begin
      eg = 8'd1 << m_owner;
      es = 3'(m_owner);
      ev = 1'b1;
      ed = data_in[m_owner*W +: W];
    end else begin
      eg = '0;
      es = '0;
      ev = 1'b0;
      ed = '0;
    end
    check({tag, ".gnt"}, 64'(gnt), 64'(eg));
    check({tag, ".sel"}, 64'(sel), 64'(es));
    check({tag, ".gnt_valid"}, 64'(gnt_valid), 64'(ev));
    check({tag, ".data_out"}, 64'(data_out), 64'(ed));
  endtask

  task automatic step(input logic [7:0] r);
    req = r;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    #2;
    model_reset();
    check_model("reset_async");
    @(posedge clk);
    #1;
    check_model("reset_held");
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    data_in = {$urandom, $urandom};
    model_reset();
    #1;
    do_reset();

    // Idle with no requests.
    for (int c = 0; c < 5; c++) begin
      data_in = {$urandom, $urandom};
      step(8'h00);
      check("idle_gnt", 64'(gnt), 64'h0);
      check("idle_data", 64'(data_out), 64'h0);
      check_model("idle");
    end

    // Back-to-back handoff 0 -> 7.
    step(8'h81);
    check("h32_gnt0", 64'(gnt), 64'h01);
    check("h32_sel0", 64'(sel), 64'd0);
    check_model("h32a");
    step(8'h80);
    check("h32_gnt7", 64'(gnt), 64'h80);
    check("h32_sel7", 64'(sel), 64'd7);
    check_model("h32b");
    step(8'h00);
    check_model("h32_idle");

    // Full rotation with wrap: 0,1,...,7,0,1.
    do_reset();
    step(8'hFF);
    check("rot_first", 64'(sel), 64'd0);
    for (int i = 1; i <= 9; i++) begin
      logic [7:0] r;
      r = 8'hFF & ~(8'd1 << ((i - 1) % 8));
      step(r);
      check("rot_sel", 64'(sel), 64'(i % 8));
      check_model("rot");
    end

    // Long hold of requesters 1 and 2.
    do_reset();
    step(8'h06);
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int c = 0; c < 9; c++) begin
      int e;
      e = (c < 4) ? 1 : (c < 8) ? 2 : 1;
      check("timeout_sel", 64'(sel), 64'(e));
      check_model("timeout");
      step(8'h06);
    end
`else
    for (int c = 0; c < 20; c++) begin
      check("hold_sel", 64'(sel), 64'd1);
      check_model("hold");
      step(8'h06);
    end
`endif

    // Asynchronous reset in the middle of a grant.
    do_reset();
    data_in = {$urandom, $urandom};
    data_in[3*W +: W] = W'(8'hA5);
    step(8'h08);
    check("rst_pre_data", 64'(data_out), 64'hA5);
    check("rst_pre_gnt", 64'(gnt), 64'h08);
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_gnt", 64'(gnt), 64'h0);
    check("rst_async_data", 64'(data_out), 64'h0);
    check("rst_async_valid", 64'(gnt_valid), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(8'h08);
    check("rst_post_gnt", 64'(gnt), 64'h08);
    check_model("rst_post");

    // Randomised traffic: hold, drop owner, or new random request vector.
    for (int c = 0; c < 400; c++) begin
      logic [7:0] r;
      int         mode;
      mode = $urandom_range(0, 9);
      r = req;
      if (mode < 3) r = 8'($urandom);
      else if (mode < 6 && m_owner >= 0) r[m_owner] = 1'b0;
      else if (mode == 6) r = 8'($urandom) & 8'($urandom);
      data_in = {$urandom, $urandom};
      step(r);
      check_model("rand");
      check("rand_onehot", 64'($countones(gnt) <= 1), 64'd1);
      data_in = {$urandom, $urandom};
      #1;
      check("rand_comb_data", 64'(data_out),
            64'((m_owner >= 0) ? data_in[m_owner*W +: W] : '0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
